id_ex_stage: RTL and testbench

ID/EX pipeline register and EX-stage operand selection for the RV32I 5-stage core. Captures decoded operands and control from Decode each cycle, then drives the ALU inputs SrcAE, SrcBE, ALUControlE and funct3E. Applies MEM/WB forwarding and A/B source selection, and supports stall (hold) and flush (bubble) requests from the hazard unit.

---
 rtl/riscv_pkg.sv | 59 +++++
 rtl/id_ex_stage_if.sv | 73 +++++++
 rtl/id_ex_stage_fwd_mux.sv | 26 ++
 rtl/id_ex_stage.sv | 97 +++++++++
 tb/tb_id_ex_stage.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the pipeline blocks.
// Holds datapath widths, the forwarding / A-source / result-source encodings,
// the ALU op codes and the ID/EX pipeline register record.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned ALUCTRL_W = 5;

  // Forwarding selects, driven by the hazard unit.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  // ALU operand A source.
  localparam logic [1:0] SRCA_REG  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  // Writeback result source.
  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  // ALU operations. All-zero is ADD, so a cleared register makes the ALU compute 0+0.
  localparam logic [ALUCTRL_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB  = 5'b00001;
  localparam logic [ALUCTRL_W-1:0] ALU_AND  = 5'b00010;
  localparam logic [ALUCTRL_W-1:0] ALU_OR   = 5'b00011;
  localparam logic [ALUCTRL_W-1:0] ALU_XOR  = 5'b00100;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT  = 5'b00101;
  localparam logic [ALUCTRL_W-1:0] ALU_SLTU = 5'b00110;
  localparam logic [ALUCTRL_W-1:0] ALU_SLL  = 5'b00111;
  localparam logic [ALUCTRL_W-1:0] ALU_SRL  = 5'b01000;
  localparam logic [ALUCTRL_W-1:0] ALU_SRA  = 5'b01001;

  // Everything captured at the ID/EX boundary.
  typedef struct packed {
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pc_plus4;
    logic [XLEN-1:0]      imm_ext;
    logic [REG_AW-1:0]    rs1;
    logic [REG_AW-1:0]    rs2;
    logic [REG_AW-1:0]    rd;
    logic                 reg_write;
    logic [1:0]           result_src;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic [ALUCTRL_W-1:0] alu_control;
    logic [2:0]           funct3;
    logic [1:0]           alu_src_a;
    logic                 alu_src_b;
    logic                 valid;
  } id_ex_regs_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: Decode-side inputs, hazard-unit controls, M/W forwarding
// values, and the EX-side outputs.
//   master : drives D-side, hazard and forwarding signals; observes E-side.
//   slave  : the stage itself; the reverse direction.
interface id_ex_stage_if;
  import riscv_pkg::*;

  // Hazard unit
  logic                 StallE;
  logic                 FlushE;
  logic [1:0]           ForwardAE;
  logic [1:0]           ForwardBE;
  // Decode side
  logic [XLEN-1:0]      RD1D;
  logic [XLEN-1:0]      RD2D;
  logic [XLEN-1:0]      PCD;
  logic [XLEN-1:0]      PCPlus4D;
  logic [XLEN-1:0]      ImmExtD;
  logic [REG_AW-1:0]    Rs1D;
  logic [REG_AW-1:0]    Rs2D;
  logic [REG_AW-1:0]    RdD;
  logic                 RegWriteD;
  logic [1:0]           ResultSrcD;
  logic                 MemWriteD;
  logic                 JumpD;
  logic                 BranchD;
  logic [ALUCTRL_W-1:0] ALUControlD;
  logic [2:0]           funct3D;
  logic [1:0]           ALUSrcAD;
  logic                 ALUSrcBD;
  // Forwarded results from later stages
  logic [XLEN-1:0]      ALUResultM;
  logic [XLEN-1:0]      ResultW;
  // Execute side
  logic [XLEN-1:0]      SrcAE;
  logic [XLEN-1:0]      SrcBE;
  logic [XLEN-1:0]      WriteDataE;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic [2:0]           funct3E;
  logic [XLEN-1:0]      PCE;
  logic [XLEN-1:0]      PCPlus4E;
  logic [XLEN-1:0]      ImmExtE;
  logic [REG_AW-1:0]    Rs1E;
  logic [REG_AW-1:0]    Rs2E;
  logic [REG_AW-1:0]    RdE;
  logic                 RegWriteE;
  logic                 MemWriteE;
  logic                 JumpE;
  logic                 BranchE;
  logic [1:0]           ResultSrcE;
  logic                 ValidE;

  modport master (
    output StallE, FlushE, ForwardAE, ForwardBE,
    output RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    output RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
    output ALUControlD, funct3D, ALUSrcAD, ALUSrcBD,
    output ALUResultM, ResultW,
    input  SrcAE, SrcBE, WriteDataE, ALUControlE, funct3E, PCE, PCPlus4E, ImmExtE,
    input  Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, JumpE, BranchE, ResultSrcE, ValidE
  );

  modport slave (
    input  StallE, FlushE, ForwardAE, ForwardBE,
    input  RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    input  RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
    input  ALUControlD, funct3D, ALUSrcAD, ALUSrcBD,
    input  ALUResultM, ResultW,
    output SrcAE, SrcBE, WriteDataE, ALUControlE, funct3E, PCE, PCPlus4E, ImmExtE,
    output Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, JumpE, BranchE, ResultSrcE, ValidE
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: 3:1 XLEN-wide forwarding mux for one ALU operand.
//   sel     : FWD_REG / FWD_W / FWD_M; the unused code 2'b11 selects the register value
//   reg_val : operand from the ID/EX register
//   w_val   : WB-stage result
//   m_val   : MEM-stage ALU result
//   fwd     : selected operand
module fwd_mux
  import riscv_pkg::*;
(
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] reg_val,
  input  logic [XLEN-1:0] w_val,
  input  logic [XLEN-1:0] m_val,
  output logic [XLEN-1:0] fwd
);

  always_comb begin
    fwd = reg_val;
    case (sel)
      FWD_W:   fwd = w_val;
      FWD_M:   fwd = m_val;
      default: fwd = reg_val;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register plus EX operand selection.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : id_ex_stage_if.slave carrying Decode inputs, stall/flush, forwarding
//           selects, M/W results and all EX-side outputs
// Priority at each edge: reset, then flush (bubble), then stall (hold), then load.
// Operand forwarding and source selection are combinational after the register,
// so they track ALUResultM / ResultW even while the register is stalled.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  id_ex_regs_t regs_q, regs_d;
  logic [XLEN-1:0] fwd_a, fwd_b;

  always_comb begin
    regs_d = regs_q;
    if (!bus.StallE) begin
      regs_d.rd1         = bus.RD1D;
      regs_d.rd2         = bus.RD2D;
      regs_d.pc          = bus.PCD;
      regs_d.pc_plus4    = bus.PCPlus4D;
      regs_d.imm_ext     = bus.ImmExtD;
      regs_d.rs1         = bus.Rs1D;
      regs_d.rs2         = bus.Rs2D;
      regs_d.rd          = bus.RdD;
      regs_d.reg_write   = bus.RegWriteD;
      regs_d.result_src  = bus.ResultSrcD;
      regs_d.mem_write   = bus.MemWriteD;
      regs_d.jump        = bus.JumpD;
      regs_d.branch      = bus.BranchD;
      regs_d.alu_control = bus.ALUControlD;
      regs_d.funct3      = bus.funct3D;
      regs_d.alu_src_a   = bus.ALUSrcAD;
      regs_d.alu_src_b   = bus.ALUSrcBD;
      regs_d.valid       = 1'b1;
    end
  end

  // A bubble is all-zero: no writes, no redirect, ALU computes ADD 0+0.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.FlushE) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  fwd_mux u_fwd_a (
    .sel     (bus.ForwardAE),
    .reg_val (regs_q.rd1),
    .w_val   (bus.ResultW),
    .m_val   (bus.ALUResultM),
    .fwd     (fwd_a)
  );

  fwd_mux u_fwd_b (
    .sel     (bus.ForwardBE),
    .reg_val (regs_q.rd2),
    .w_val   (bus.ResultW),
    .m_val   (bus.ALUResultM),
    .fwd     (fwd_b)
  );

  always_comb begin
    bus.SrcAE = fwd_a;
    case (regs_q.alu_src_a)
      SRCA_PC:   bus.SrcAE = regs_q.pc;
      SRCA_ZERO: bus.SrcAE = '0;
      default:   bus.SrcAE = fwd_a;
    endcase
  end

  assign bus.SrcBE       = regs_q.alu_src_b ? regs_q.imm_ext : fwd_b;
  // Store data is always the forwarded rs2, even when B takes the immediate.
  assign bus.WriteDataE  = fwd_b;

  assign bus.ALUControlE = regs_q.alu_control;
  assign bus.funct3E     = regs_q.funct3;
  assign bus.PCE         = regs_q.pc;
  assign bus.PCPlus4E    = regs_q.pc_plus4;
  assign bus.ImmExtE     = regs_q.imm_ext;
  assign bus.Rs1E        = regs_q.rs1;
  assign bus.Rs2E        = regs_q.rs2;
  assign bus.RdE         = regs_q.rd;
  assign bus.RegWriteE   = regs_q.reg_write;
  assign bus.MemWriteE   = regs_q.mem_write;
  assign bus.JumpE       = regs_q.jump;
  assign bus.BranchE     = regs_q.branch;
  assign bus.ResultSrcE  = regs_q.result_src;
  assign bus.ValidE      = regs_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a directed vector table plus hand-written
// stall / flush sequences.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [1:0]  src_a;
    logic        src_b;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] alu_m;
    logic [31:0] res_w;
    logic [31:0] e_srca;
    logic [31:0] e_srcb;
    logic [31:0] e_wd;
    logic [4:0]  e_rd;
    logic        e_valid;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Constant defaults for the D-side fields the table does not vary.
  task automatic drive_defaults();
    bus.PCPlus4D    = bus.PCD + 32'd4;
    bus.Rs1D        = 5'd1;
    bus.Rs2D        = 5'd2;
    bus.RegWriteD   = 1'b1;
    bus.ResultSrcD  = RESULT_ALU;
    bus.MemWriteD   = 1'b0;
    bus.JumpD       = 1'b0;
    bus.BranchD     = 1'b0;
    bus.ALUControlD = ALU_ADD;
    bus.funct3D     = 3'b000;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    //            rst stl fl  rd1         rd2   pc          imm         rd  sa   sb  fa   fb
    //            alu_m      res_w      e_srca      e_srcb      e_wd        e_rd val
    vecs[0]  = '{0, 0, 0, 32'h11, 32'h22, 32'h40, 32'h8, 7, 2'd0, 0, 2'd0, 2'd0,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0};
    vecs[1]  = '{0, 0, 0, 32'h11, 32'h22, 32'h40, 32'h8, 7, 2'd0, 0, 2'd0, 2'd0,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0};
    vecs[2]  = '{1, 0, 0, 32'd10, 32'd10, 32'h0, 32'h0, 1, 2'd0, 0, 2'd0, 2'd0,
                 32'h0, 32'h0, 32'd10, 32'd10, 32'd10, 1, 1};
    vecs[3]  = '{1, 0, 0, 32'd5, 32'd6, 32'h0, 32'h0, 2, 2'd0, 0, 2'd2, 2'd0,
                 32'h64, 32'h20, 32'h64, 32'd6, 32'd6, 2, 1};
    vecs[4]  = '{1, 0, 0, 32'd5, 32'd6, 32'h0, 32'h0, 2, 2'd0, 0, 2'd1, 2'd0,
                 32'h64, 32'h20, 32'h20, 32'd6, 32'd6, 2, 1};
    vecs[5]  = '{1, 0, 0, 32'd5, 32'd6, 32'h0, 32'h0, 2, 2'd0, 0, 2'd3, 2'd0,
                 32'h64, 32'h20, 32'd5, 32'd6, 32'd6, 2, 1};
    vecs[6]  = '{1, 0, 0, 32'd5, 32'd6, 32'h0, 32'h0, 2, 2'd0, 0, 2'd0, 2'd2,
                 32'h64, 32'h20, 32'd5, 32'h64, 32'h64, 2, 1};
    vecs[7]  = '{1, 0, 0, 32'd5, 32'd6, 32'h0, 32'h0, 2, 2'd0, 0, 2'd0, 2'd1,
                 32'h64, 32'h20, 32'd5, 32'h20, 32'h20, 2, 1};
    vecs[8]  = '{1, 0, 0, 32'd5, 32'd6, 32'h0, 32'h0, 2, 2'd0, 0, 2'd0, 2'd3,
                 32'h64, 32'h20, 32'd5, 32'd6, 32'd6, 2, 1};
    vecs[9]  = '{1, 0, 0, 32'd5, 32'd7, 32'h0, 32'hFFFFFFFC, 4, 2'd0, 1, 2'd0, 2'd2,
                 32'd9, 32'h20, 32'd5, 32'hFFFFFFFC, 32'd9, 4, 1};
    vecs[10] = '{1, 0, 0, 32'd5, 32'd7, 32'h1000, 32'h0, 4, 2'd1, 0, 2'd0, 2'd0,
                 32'd9, 32'h20, 32'h1000, 32'd7, 32'd7, 4, 1};
    vecs[11] = '{1, 0, 0, 32'd5, 32'd7, 32'h1000, 32'h0, 4, 2'd2, 0, 2'd0, 2'd0,
                 32'd9, 32'h20, 32'h0, 32'd7, 32'd7, 4, 1};
    vecs[12] = '{1, 0, 1, 32'd5, 32'd7, 32'h1000, 32'h0, 4, 2'd0, 0, 2'd0, 2'd0,
                 32'd9, 32'h20, 32'h0, 32'h0, 32'h0, 0, 0};
    vecs[13] = '{1, 0, 0, 32'h33, 32'h44, 32'h0, 32'h0, 3, 2'd0, 0, 2'd0, 2'd0,
                 32'd9, 32'h20, 32'h33, 32'h44, 32'h44, 3, 1};
    vecs[14] = '{1, 1, 0, 32'h99, 32'h88, 32'h0, 32'h0, 9, 2'd0, 0, 2'd0, 2'd0,
                 32'd9, 32'h20, 32'h33, 32'h44, 32'h44, 3, 1};
    vecs[15] = '{1, 1, 1, 32'h99, 32'h88, 32'h0, 32'h0, 9, 2'd0, 0, 2'd0, 2'd0,
                 32'd9, 32'h20, 32'h0, 32'h0, 32'h0, 0, 0};
    vecs[16] = '{1, 0, 0, 32'h12, 32'h34, 32'h0, 32'h0, 5, 2'd0, 0, 2'd0, 2'd0,
                 32'd9, 32'h20, 32'h12, 32'h34, 32'h34, 5, 1};
    vecs[17] = '{0, 1, 0, 32'h12, 32'h34, 32'h0, 32'h0, 5, 2'd0, 0, 2'd0, 2'd0,
                 32'd9, 32'h20, 32'h0, 32'h0, 32'h0, 0, 0};

    for (int i = 0; i < 18; i++) begin
      rst_n          = vecs[i].rst_n;
      bus.StallE     = vecs[i].stall;
      bus.FlushE     = vecs[i].flush;
      bus.RD1D       = vecs[i].rd1;
      bus.RD2D       = vecs[i].rd2;
      bus.PCD        = vecs[i].pc;
      bus.ImmExtD    = vecs[i].imm;
      bus.RdD        = vecs[i].rd;
      bus.ALUSrcAD   = vecs[i].src_a;
      bus.ALUSrcBD   = vecs[i].src_b;
      bus.ForwardAE  = vecs[i].fwd_a;
      bus.ForwardBE  = vecs[i].fwd_b;
      bus.ALUResultM = vecs[i].alu_m;
      bus.ResultW    = vecs[i].res_w;
      drive_defaults();
      @(posedge clk);
      #1;
      chk($sformatf("v%0d SrcAE", i), bus.SrcAE, vecs[i].e_srca);
      chk($sformatf("v%0d SrcBE", i), bus.SrcBE, vecs[i].e_srcb);
      chk($sformatf("v%0d WriteDataE", i), bus.WriteDataE, vecs[i].e_wd);
      chk($sformatf("v%0d RdE", i), {27'd0, bus.RdE}, {27'd0, vecs[i].e_rd});
      chk($sformatf("v%0d ValidE", i), {31'd0, bus.ValidE}, {31'd0, vecs[i].e_valid});
      // Every loaded vector has RegWriteD = 1, so RegWriteE follows validity.
      chk($sformatf("v%0d RegWriteE", i), {31'd0, bus.RegWriteE}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d ALUControlE", i), {27'd0, bus.ALUControlE}, 32'd0);
    end

    // Stall sequence: load a full instruction, then hold it 3 cycles while D changes.
    rst_n           = 1'b1;
    bus.StallE      = 1'b0;
    bus.FlushE      = 1'b0;
    bus.ForwardAE   = FWD_REG;
    bus.ForwardBE   = FWD_REG;
    bus.RD1D        = 32'h5;
    bus.RD2D        = 32'h6;
    bus.PCD         = 32'h200;
    bus.PCPlus4D    = 32'h204;
    bus.ImmExtD     = 32'h10;
    bus.Rs1D        = 5'd6;
    bus.Rs2D        = 5'd7;
    bus.RdD         = 5'd3;
    bus.RegWriteD   = 1'b1;
    bus.ResultSrcD  = RESULT_MEM;
    bus.MemWriteD   = 1'b1;
    bus.JumpD       = 1'b0;
    bus.BranchD     = 1'b1;
    bus.ALUControlD = ALU_SUB;
    bus.funct3D     = 3'b010;
    bus.ALUSrcAD    = SRCA_REG;
    bus.ALUSrcBD    = 1'b0;
    @(posedge clk);
    #1;
    chk("load PCE", bus.PCE, 32'h200);
    chk("load PCPlus4E", bus.PCPlus4E, 32'h204);
    chk("load ResultSrcE", {30'd0, bus.ResultSrcE}, {30'd0, RESULT_MEM});

    bus.StallE      = 1'b1;
    bus.RD1D        = 32'h77;
    bus.PCD         = 32'h300;
    bus.PCPlus4D    = 32'h304;
    bus.ImmExtD     = 32'h20;
    bus.Rs1D        = 5'd9;
    bus.RdD         = 5'd8;
    bus.MemWriteD   = 1'b0;
    bus.BranchD     = 1'b0;
    bus.JumpD       = 1'b1;
    bus.ALUControlD = 5'h1f;
    bus.funct3D     = 3'b111;
    bus.ForwardAE   = FWD_M;
    for (int c = 0; c < 3; c++) begin
      bus.ALUResultM = 32'hAAA0 + c;
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d RdE", c), {27'd0, bus.RdE}, 32'd3);
      chk($sformatf("stall%0d Rs1E", c), {27'd0, bus.Rs1E}, 32'd6);
      chk($sformatf("stall%0d PCE", c), bus.PCE, 32'h200);
      chk($sformatf("stall%0d ImmExtE", c), bus.ImmExtE, 32'h10);
      chk($sformatf("stall%0d ALUControlE", c), {27'd0, bus.ALUControlE}, {27'd0, ALU_SUB});
      chk($sformatf("stall%0d funct3E", c), {29'd0, bus.funct3E}, 32'd2);
      chk($sformatf("stall%0d MemWriteE", c), {31'd0, bus.MemWriteE}, 32'd1);
      chk($sformatf("stall%0d BranchE", c), {31'd0, bus.BranchE}, 32'd1);
      chk($sformatf("stall%0d JumpE", c), {31'd0, bus.JumpE}, 32'd0);
      chk($sformatf("stall%0d ValidE", c), {31'd0, bus.ValidE}, 32'd1);
      chk($sformatf("stall%0d SrcAE", c), bus.SrcAE, 32'hAAA0 + c);
      // Forwarded value must follow ALUResultM without an edge.
      bus.ALUResultM = 32'hBEEF0 + c;
      #1;
      chk($sformatf("stall%0d SrcAE comb", c), bus.SrcAE, 32'hBEEF0 + c);
    end

    // Flush and stall together: flush wins.
    bus.FlushE    = 1'b1;
    bus.ForwardAE = FWD_REG;
    @(posedge clk);
    #1;
    chk("flush RegWriteE", {31'd0, bus.RegWriteE}, 32'd0);
    chk("flush MemWriteE", {31'd0, bus.MemWriteE}, 32'd0);
    chk("flush BranchE", {31'd0, bus.BranchE}, 32'd0);
    chk("flush RdE", {27'd0, bus.RdE}, 32'd0);
    chk("flush ValidE", {31'd0, bus.ValidE}, 32'd0);
    chk("flush SrcAE", bus.SrcAE, 32'd0);

    // Next non-stalled edge loads the current D values.
    bus.FlushE = 1'b0;
    bus.StallE = 1'b0;
    @(posedge clk);
    #1;
    chk("reload RdE", {27'd0, bus.RdE}, 32'd8);
    chk("reload ValidE", {31'd0, bus.ValidE}, 32'd1);
    chk("reload JumpE", {31'd0, bus.JumpE}, 32'd1);
    chk("reload SrcAE", bus.SrcAE, 32'h77);
    chk("reload funct3E", {29'd0, bus.funct3E}, 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
